// File: rtl/spdif_rx.sv
// spdif_rx: S/PDIF biphase-mark receiver.
// Recovers 16-bit L/R samples from an oversampled line.
module spdif_rx #(
  parameter int CLK_RATE_KHZ = 49152,
  parameter int AUDIO_RATE   = 48000,
  parameter int UI_CLKS      = (CLK_RATE_KHZ*1000)/(AUDIO_RATE*128),
  parameter int LOCK_FRAMES  = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        spdif_i,
  output logic [31:0] sample_o,
  output logic        sample_valid_o,
  output logic        locked_o,
  output logic        parity_err_o,
  output logic        decode_err_o
);

  localparam logic [7:0] T1 = 8'(UI_CLKS/2);
  localparam logic [7:0] T3 = 8'(3*UI_CLKS/2);
  localparam logic [7:0] T5 = 8'(5*UI_CLKS/2);
  localparam logic [7:0] T7 = 8'(7*UI_CLKS/2);
  localparam int LW = $clog2(LOCK_FRAMES+1);
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_FRAMES);

  typedef enum logic [1:0] {HUNT, PRE, DATA} state_t;
  typedef enum logic [1:0] {C_BAD, C_1UI, C_2UI, C_3UI} code_t;

  state_t state, state_n;
  code_t code, c0, c0_n, c1, c1_n;
  logic sync1, sync2, prev, edg;
  logic [7:0] cnt;
  logic [1:0] pidx, pidx_n;
  logic [4:0] bitcnt, bitcnt_n;
  logic half, half_n;
  logic is_left, is_left_n;
  logic par, par_n;
  logic lv, lv_n;
  logic [15:0] aud, aud_n;
  logic [15:0] lhold, lhold_n;
  logic [31:0] samp_n;
  logic sv_n, pe_n, de_n;
  logic [LW-1:0] lock, lock_n;
  logic bit_ev, bit_v;

  assign edg = sync2 ^ prev;
  assign locked_o = (lock == LOCK_MAX);

  // two-stage synchronizer plus one tap for edge detection
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= spdif_i;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // saturating edge-to-edge interval counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      cnt <= 8'd0;
    else if (edg)
      cnt <= 8'd1;
    else if (cnt != 8'hFF)
      cnt <= cnt + 8'd1;
  end

  // classify the interval that ends at the current edge
  always_comb begin
    code = C_BAD;
    if (cnt < T1)
      code = C_BAD;
    else if (cnt < T3)
      code = C_1UI;
    else if (cnt < T5)
      code = C_2UI;
    else if (cnt < T7)
      code = C_3UI;
  end

  // next-state, bit decode, subframe close and error handling
  always_comb begin
    state_n   = state;
    pidx_n    = pidx;
    c0_n      = c0;
    c1_n      = c1;
    bitcnt_n  = bitcnt;
    half_n    = half;
    is_left_n = is_left;
    par_n     = par;
    lv_n      = lv;
    aud_n     = aud;
    lhold_n   = lhold;
    samp_n    = sample_o;
    sv_n      = 1'b0;
    pe_n      = 1'b0;
    de_n      = 1'b0;
    lock_n    = lock;
    bit_ev    = 1'b0;
    bit_v     = 1'b0;
    if (edg) begin
      unique case (state)
        HUNT: begin
          if (code == C_3UI) begin
            state_n = PRE;
            pidx_n  = 2'd0;
          end
        end
        PRE: begin
          if (code == C_BAD)
            de_n = 1'b1;
          else if (pidx == 2'd0) begin
            c0_n   = code;
            pidx_n = 2'd1;
          end else if (pidx == 2'd1) begin
            c1_n   = code;
            pidx_n = 2'd2;
          end else begin
            bitcnt_n = 5'd4;
            half_n   = 1'b0;
            par_n    = 1'b0;
            aud_n    = 16'd0;
            if (c0 == C_1UI && c1 == C_1UI
                && code == C_3UI) begin
              state_n   = DATA;
              is_left_n = 1'b1;
            end else if (c0 == C_3UI
                && c1 == C_1UI
                && code == C_1UI) begin
              state_n   = DATA;
              is_left_n = 1'b1;
            end else if (c0 == C_2UI
                && c1 == C_1UI
                && code == C_2UI) begin
              state_n   = DATA;
              is_left_n = 1'b0;
            end else
              de_n = 1'b1;
          end
        end
        DATA: begin
          if (!half) begin
            if (code == C_2UI)
              bit_ev = 1'b1;
            else if (code == C_1UI)
              half_n = 1'b1;
            else
              de_n = 1'b1;
          end else begin
            if (code == C_1UI) begin
              bit_ev = 1'b1;
              bit_v  = 1'b1;
              half_n = 1'b0;
            end else
              de_n = 1'b1;
          end
        end
        default: state_n = HUNT;
      endcase
    end else if (state != HUNT && cnt == T7) begin
      de_n = 1'b1;
    end

    if (bit_ev) begin
      par_n    = par ^ bit_v;
      bitcnt_n = bitcnt + 5'd1;
      if (bitcnt >= 5'd12 && bitcnt <= 5'd27)
        aud_n = {bit_v, aud[15:1]};
      if (bitcnt == 5'd31) begin
        state_n = HUNT;
        if (par ^ bit_v) begin
          pe_n   = 1'b1;
          lv_n   = 1'b0;
          lock_n = '0;
        end else if (is_left) begin
          lhold_n = aud;
          lv_n    = 1'b1;
        end else if (lv) begin
          samp_n = {aud, lhold};
          sv_n   = 1'b1;
          lv_n   = 1'b0;
          lock_n = (lock == LOCK_MAX) ? lock
                   : lock + 1'b1;
        end
      end
    end

    if (de_n) begin
      state_n = HUNT;
      lv_n    = 1'b0;
      lock_n  = '0;
      sv_n    = 1'b0;
      pe_n    = 1'b0;
      samp_n  = sample_o;
    end
  end

  // decoder state and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= HUNT;
      pidx           <= 2'd0;
      c0             <= C_BAD;
      c1             <= C_BAD;
      bitcnt         <= 5'd0;
      half           <= 1'b0;
      is_left        <= 1'b0;
      par            <= 1'b0;
      lv             <= 1'b0;
      aud            <= 16'd0;
      lhold          <= 16'd0;
      sample_o       <= 32'd0;
      sample_valid_o <= 1'b0;
      parity_err_o   <= 1'b0;
      decode_err_o   <= 1'b0;
      lock           <= '0;
    end else begin
      state          <= state_n;
      pidx           <= pidx_n;
      c0             <= c0_n;
      c1             <= c1_n;
      bitcnt         <= bitcnt_n;
      half           <= half_n;
      is_left        <= is_left_n;
      par            <= par_n;
      lv             <= lv_n;
      aud            <= aud_n;
      lhold          <= lhold_n;
      sample_o       <= samp_n;
      sample_valid_o <= sv_n;
      parity_err_o   <= pe_n;
      decode_err_o   <= de_n;
      lock           <= lock_n;
    end
  end

endmodule
